// File: rtl/uart_sram_tx_dump_if.sv
// SRAM read port used by the UART dump engine; the engine is the master and
// only ever reads.
interface uart_sram_tx_dump_if;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic        SRAM_we_n;

    modport master (
        output SRAM_address,
        output SRAM_we_n,
        input  SRAM_read_data
    );

    modport slave (
        input  SRAM_address,
        input  SRAM_we_n,
        output SRAM_read_data
    );
endinterface

// File: rtl/uart_sram_tx_dump.sv
// Reads a run of 16-bit SRAM words and sends each one as two 8N1 UART bytes,
// high byte first. Used to dump decoded image regions back to the host.
module uart_sram_tx_dump #(
    parameter int unsigned CLK_PER_BIT  = 434,
    parameter int unsigned SRAM_LATENCY = 2
) (
    input  logic                       CLOCK_50_I,
    input  logic                       resetn,
    input  logic                       Start,
    input  logic                       Abort,
    input  logic [17:0]                Base_address,
    input  logic [17:0]                Word_count,
    uart_sram_tx_dump_if.master        sram,
    output logic                       UART_TX_O,
    output logic                       Busy,
    output logic                       Done,
    output logic [17:0]                Words_sent
);

    localparam logic [8:0] BaudReload = 9'(CLK_PER_BIT - 1);
    localparam logic [7:0] WaitReload = 8'(SRAM_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle, StRead, StWait, StLatch, StStartBit, StData, StStop, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        byte_sel_q, byte_sel_d;
    logic [15:0] word_q, word_d;
    logic [17:0] addr_q, addr_d;
    logic [17:0] remaining_q, remaining_d;
    logic [17:0] words_sent_q, words_sent_d;
    logic [7:0]  wait_q, wait_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        baud_end;
    logic [7:0]  cur_byte;

    assign baud_end = (baud_q == 9'd0);
    assign cur_byte = byte_sel_q ? word_q[15:8] : word_q[7:0];

    // Line driver is a flop reset to 1 so a reset mid-frame cannot glitch low.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            baud_q       <= 9'd0;
            bit_idx_q    <= 3'd0;
            byte_sel_q   <= 1'b0;
            word_q       <= 16'd0;
            addr_q       <= 18'd0;
            remaining_q  <= 18'd0;
            words_sent_q <= 18'd0;
            wait_q       <= 8'd0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            byte_sel_q   <= byte_sel_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            words_sent_q <= words_sent_d;
            wait_q       <= wait_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_idx_d    = bit_idx_q;
        byte_sel_d   = byte_sel_q;
        word_d       = word_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        words_sent_d = words_sent_q;
        wait_d       = wait_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    addr_d       = Base_address;
                    remaining_d  = Word_count;
                    words_sent_d = 18'd0;
                    state_d      = (Word_count == 18'd0) ? StDone : StRead;
                end
            end
            StRead: begin
                wait_d  = WaitReload;
                state_d = StWait;
            end
            StWait: begin
                if (wait_q == 8'd0) state_d = StLatch;
                else                wait_d  = wait_q - 8'd1;
            end
            StLatch: begin
                word_d     = sram.SRAM_read_data;
                byte_sel_d = 1'b1;
                baud_d     = BaudReload;
                state_d    = StStartBit;
            end
            StStartBit: begin
                if (baud_end) begin
                    baud_d    = BaudReload;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q - 9'd1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d = BaudReload;
                    if (bit_idx_q == 3'd7) state_d   = StStop;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    baud_d = baud_q - 9'd1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = BaudReload;
                    // A completed low byte always retires its word, even when aborting.
                    if (!byte_sel_q) begin
                        words_sent_d = words_sent_q + 18'd1;
                        remaining_d  = remaining_q - 18'd1;
                        addr_d       = addr_q + 18'd1;
                    end
                    if (Abort)                      state_d = StDone;
                    else if (byte_sel_q) begin
                        byte_sel_d = 1'b0;
                        state_d    = StStartBit;
                    end
                    else if (remaining_q == 18'd1) state_d = StDone;
                    else                            state_d = StRead;
                end else begin
                    baud_d = baud_q - 9'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_d = busy_q;
        done_d = 1'b0;
        unique case (state_q)
            StIdle:     if (Start) busy_d = 1'b1;
            StStartBit: tx_d = 1'b0;
            StData:     tx_d = cur_byte[bit_idx_q];
            StDone: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default:    tx_d = 1'b1;
        endcase
    end

    // A zero-length request never touches SRAM, so the address stays parked at 0.
    assign sram.SRAM_address = (state_q == StIdle || remaining_q == 18'd0) ? 18'd0 : addr_q;
    assign sram.SRAM_we_n    = 1'b1;
    assign UART_TX_O         = tx_q;
    assign Busy              = busy_q;
    assign Done              = done_q;
    assign Words_sent        = words_sent_q;

endmodule

// File: doc/uart_sram_tx_dump.md
Name: uart_sram_tx_dump

Overview:
- Transmit engine for the UART pin that is currently tied high at top level.
- On Start, reads Word_count 16-bit words from SRAM, beginning at Base_address, and serialises each word as two 8N1 UART bytes (high byte first) on UART_TX_O.
- It is the reverse direction of the UART receive-to-SRAM path. Used to dump decoded image regions back to the host PC.
- Top level grants it the SRAM port only while Busy is high.

Parameters:
- CLK_PER_BIT, 434, CLOCK_50_I cycles per UART bit (115200 baud at 50 MHz).
- SRAM_LATENCY, 2, cycles from SRAM_address driven to SRAM_read_data valid.

Ports:
- CLOCK_50_I  input  1  50 MHz system clock.
- resetn  input  1  asynchronous, active-low reset.
- Start  input  1  single-cycle request; sampled only in S_IDLE.
- Abort  input  1  level; stops the dump at the next byte boundary.
- Base_address  input  18  first SRAM word address; latched on accepted Start.
- Word_count  input  18  number of words to send; latched on accepted Start.
- SRAM_address  output  18  SRAM word address.
- SRAM_read_data  input  16  SRAM read data.
- SRAM_we_n  output  1  constant 1 (read-only master).
- UART_TX_O  output  1  serial line; idle high.
- Busy  output  1  high from accepted Start until Done.
- Done  output  1  one-cycle pulse at completion or abort.
- Words_sent  output  18  count of fully transmitted words.

Behaviour:
- Reset values: UART_TX_O=1, Busy=0, Done=0, SRAM_address=0, Words_sent=0, SRAM_we_n=1, state S_IDLE.
  - Reset mid-frame ends the frame immediately with the line high. No glitch low is allowed.
- S_IDLE:
  - Start=1 latches Base_address into addr_reg and Word_count into remaining, clears Words_sent, sets Busy=1.
  - If Word_count=0: go to S_DONE; no SRAM access, no UART activity.
  - Otherwise: go to S_READ.
- S_READ: drive SRAM_address=addr_reg, then wait SRAM_LATENCY cycles (S_WAIT counter).
- S_LATCH: capture SRAM_read_data into word_reg, set byte_sel=1 (high byte), go to S_START_BIT.
- Frame timing:
  - S_START_BIT: UART_TX_O=0 for CLK_PER_BIT cycles.
  - S_DATA: 8 bits, LSB first, each CLK_PER_BIT cycles. Bit source is word_reg[15:8] when byte_sel=1, word_reg[7:0] when byte_sel=0.
  - S_STOP: UART_TX_O=1 for CLK_PER_BIT cycles.
  - A frame is exactly 10*CLK_PER_BIT cycles.
- Baud counter is 9 bits wide and reloads at CLK_PER_BIT-1 and counts down. Bit index is 3 bits wide.
- End of stop bit:
  - If Abort=1: go to S_DONE. Words_sent counts only words whose low byte completed.
  - Else if byte_sel=1: set byte_sel=0 and go to S_START_BIT. No idle gap between the two bytes of a word.
  - Else: Words_sent+1, remaining-1, addr_reg+1.
    - addr_reg wraps from 18'h3FFFF to 0.
    - Go to S_DONE if remaining becomes 0, else S_READ.
- Between words the line stays high for SRAM_LATENCY+2 cycles (S_READ, S_WAIT, S_LATCH).
- S_DONE: Done=1 for one cycle, Busy=0, then S_IDLE. Words_sent holds its value until the next Start.
- Start while Busy is ignored. Start and Abort high in the same cycle in S_IDLE: the Start is accepted; Abort is evaluated only at byte boundaries.
- Abort asserted in S_READ/S_WAIT/S_LATCH has no effect until the next stop-bit end.
  - Consequence: the current word's high byte is still sent, and the abort takes effect at the end of that byte's stop bit.
- SRAM_address holds addr_reg in every non-idle state and holds 0 in S_IDLE.

Test Plan:
- Reset then idle 1000 cycles -> UART_TX_O=1, Busy=0, Done=0, SRAM_address=0.
- SRAM[100]=16'hA55A, Start with Base=100, Count=1 -> line carries 0xA5 then 0x5A.
  - Each bit lasts 434 cycles; a host-side UART model decodes both bytes.
  - Done pulses once, 8680 cycles after the first start bit; Words_sent=1.
- Base=18'h3FFFF, Count=2, SRAM[3FFFF]=16'h1234, SRAM[0]=16'h5678 -> bytes 12,34,56,78 in order; SRAM_address sequence is 3FFFF then 0.
- Count=0 -> Done exactly 2 cycles after Start; UART_TX_O never low; SRAM_address stays 0.
- Count=4, Abort raised mid-data of byte 3 (high byte of word 2) -> byte 3 completes including its stop bit, then Done; Words_sent=1; no further start bits.
- Start pulsed again during an active dump of Count=3 -> ignored; exactly 6 bytes sent. Then resetn low mid-frame -> UART_TX_O=1 immediately, Busy=0.
